// File: rtl/mem_access_unit.sv
// mem_access_unit
// ---------------
// Initiator side of the data-memory interface. It takes one byte-addressed
// load/store request at a time from the MEM stage. It drives a word-addressed,
// single-port synchronous memory with a read latency of one cycle. It returns
// either extended load data or a store acknowledge as a one-cycle pulse.
//
// Optional feature macro: LSU_SUBWORD_EN
//   defined   : byte and half loads/stores are supported. Sub-word stores
//               use a read-modify-write sequence.
//   undefined : only word accesses are legal. Every other size is answered
//               with an error response.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   req_valid / req_ready   request handshake
//   req_write               1 = store, 0 = load
//   req_size                0 byte, 1 half, 2 word, 3 illegal
//   req_signed              load extension: 1 sign, 0 zero
//   req_addr, req_wdata     byte address, right-aligned store data
//   resp_valid              one-cycle completion pulse
//   resp_err                qualifies resp_valid (error response)
//   resp_rdata              extended load data (0 for stores and errors)
//   mem_address             word index driven to the memory
//   mem_writeData           word written to the memory
//   mem_MemRead             memory read strobe
//   mem_MemWrite            memory write strobe
//   mem_readData            memory read data, valid the cycle after a read
//   dbg_state               current FSM state, for observation only
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// All request fields are captured on that edge. req_ready is high only in IDLE
// and only while out of reset. Responses cannot be back-pressured. resp_valid
// rises in the first IDLE cycle after completion, and a new request may be
// accepted in that same cycle.
module mem_access_unit #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  input  logic [DATA_W-1:0] mem_readData,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD_RD  = 3'd1,
    LD_CAP = 3'd2,
    ST_WR  = 3'd3,
    RMW_RD = 3'd4,
    RMW_WR = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [DATA_W:0] ADDR_LIMIT = (DATA_W+1)'(4 * DEPTH);

  state_t            state, state_nx;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic accept;
  logic size_bad, align_bad, range_bad, req_bad;
  logic done;

  // Pick the addressed lane out of a memory word and extend it to full width.
  function automatic logic [DATA_W-1:0] load_extract(
    input logic [DATA_W-1:0] w,
    input logic [1:0]        size,
    input logic              sgn,
    input logic [1:0]        lane
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (size)
      2'd0:    return {{(DATA_W-8){sgn & b[7]}}, b};
      2'd1:    return {{(DATA_W-16){sgn & h[15]}}, h};
      default: return w;
    endcase
  endfunction

`ifdef LSU_SUBWORD_EN
  // Replace the addressed byte or half of the old memory word.
  function automatic logic [DATA_W-1:0] lane_merge(
    input logic [DATA_W-1:0] w,
    input logic [15:0]       wd,
    input logic [1:0]        size,
    input logic [1:0]        lane
  );
    logic [DATA_W-1:0] m;
    m = w;
    if (size == 2'd0) m[{lane, 3'b000} +: 8] = wd[7:0];
    else              m[{lane[1], 4'b0000} +: 16] = wd;
    return m;
  endfunction
`endif

  assign req_ready = (state == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;
  assign dbg_state = state;

  // Request legality. Every failing check leads to the same ERR path, so the
  // checks are simply ORed together.
  always_comb begin
    size_bad  = 1'b0;
    align_bad = 1'b0;
`ifdef LSU_SUBWORD_EN
    size_bad  = (req_size == 2'd3);
    align_bad = ((req_size == 2'd1) && req_addr[0]) ||
                ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
`else
    size_bad  = (req_size != 2'd2);
    align_bad = (req_addr[1:0] != 2'b00);
`endif
    range_bad = ({1'b0, req_addr} >= ADDR_LIMIT);
    req_bad   = size_bad || align_bad || range_bad;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_bad)        state_nx = ERR;
          else if (!req_write) state_nx = LD_RD;
`ifdef LSU_SUBWORD_EN
          else if (req_size != 2'd2) state_nx = RMW_RD;
`endif
          else                 state_nx = ST_WR;
        end
      end
      LD_RD:  state_nx = LD_CAP;
      LD_CAP: state_nx = IDLE;
      ST_WR:  state_nx = IDLE;
`ifdef LSU_SUBWORD_EN
      RMW_RD: state_nx = RMW_WR;
      RMW_WR: state_nx = IDLE;
`endif
      ERR:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The memory strobes are gated by rst_n. As a result, asserting reset in the
  // middle of an operation never reaches the memory.
  always_comb begin
    mem_MemRead   = 1'b0;
    mem_MemWrite  = 1'b0;
    mem_writeData = '0;
    mem_address   = '0;
    if (state != IDLE) mem_address = {2'b00, addr_q[DATA_W-1:2]};
    case (state)
      LD_RD:  mem_MemRead = rst_n;
      ST_WR: begin
        mem_MemWrite  = rst_n;
        mem_writeData = wdata_q;
      end
`ifdef LSU_SUBWORD_EN
      RMW_RD: mem_MemRead = rst_n;
      // mem_readData still holds the word read in RMW_RD, because no read is
      // issued in this cycle.
      RMW_WR: begin
        mem_MemWrite  = rst_n;
        mem_writeData = lane_merge(mem_readData, wdata_q[15:0], size_q, addr_q[1:0]);
      end
`endif
      default: ;
    endcase
  end

  assign done = (state == LD_CAP) || (state == ST_WR) ||
                (state == RMW_WR) || (state == ERR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      size_q     <= 2'd0;
      sgn_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state      <= state_nx;
      resp_valid <= done;
      resp_err   <= (state == ERR);
      resp_rdata <= (state == LD_CAP) ?
                    load_extract(mem_readData, size_q, sgn_q, addr_q[1:0]) : '0;
      if (accept) begin
        size_q  <= req_size;
        sgn_q   <= req_signed;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface. Sits between the pipeline MEM stage and the word-addressed, single-port data memory.
- Accepts one byte-addressed load/store request at a time and drives the memory's address, writeData, MemRead and MemWrite.
- Captures readData after the memory's one-cycle synchronous read latency.
- Returns sign/zero-extended load data or a store acknowledge. Supports sub-word accesses via read-modify-write.

Parameters:
- DATA_W, 32, data and address width (memory word width).
- DEPTH, 1024, number of memory words; legal byte addresses are 0 .. 4*DEPTH-1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  input  DATA_W  byte address
- req_wdata  input  DATA_W  store data, right-aligned
- resp_valid  output  1  one-cycle completion pulse
- resp_err  output  1  qualifies resp_valid: misaligned, illegal size or out-of-range access
- resp_rdata  output  DATA_W  extended load data; 0 for stores and errors
- mem_address  output  DATA_W  word index = req_addr >> 2, zero-extended
- mem_writeData  output  DATA_W  word to write
- mem_MemRead  output  1  read strobe
- mem_MemWrite  output  1  write strobe
- mem_readData  input  DATA_W  memory read port, valid the cycle after mem_MemRead

Behaviour:
- Reset: rst_n sampled low forces state IDLE and clears resp_valid, resp_err and resp_rdata to 0. mem_MemRead and mem_MemWrite are combinationally gated by rst_n, so no memory access occurs while rst_n is low, including mid-operation. An abandoned store leaves memory unchanged; no response is issued.
- States: IDLE, LD_RD, LD_CAP, ST_WR, RMW_RD, RMW_WR, ERR.
- Handshake:
  - req_ready = (state == IDLE) && rst_n.
  - A request is accepted on an edge where req_valid && req_ready. All request fields are latched on that edge.
  - No response backpressure: resp_valid is a registered one-cycle pulse, asserted in the first IDLE cycle after completion. req_ready is high in that same cycle, so back-to-back requests are allowed.
- Checks at accept, in priority order; any failure goes to ERR with no memory strobe:
  - req_size == 3
  - half with addr[0] != 0
  - word with addr[1:0] != 0
  - req_addr >= 4*DEPTH
- ERR: lasts one cycle, then IDLE with resp_valid=1, resp_err=1, resp_rdata=0. Latency accept -> resp_valid = 2 cycles.
- Load path:
  - LD_RD drives mem_MemRead=1 and mem_address.
  - LD_CAP selects the lane from mem_readData and registers the extended result.
  - Then IDLE with resp_valid=1. Latency = 3 cycles.
- Word store path:
  - ST_WR drives mem_MemWrite=1 and mem_writeData=req_wdata.
  - Then IDLE with resp_valid=1. Latency = 2 cycles.
- Sub-word store path:
  - RMW_RD drives mem_MemRead=1.
  - RMW_WR drives mem_MemWrite=1 with mem_writeData = mem_readData with the addressed lane replaced by req_wdata[7:0] or [15:0]. mem_readData holds because MemRead is 0 in RMW_WR.
  - Latency = 3 cycles.
- Lanes are little-endian:
  - Byte k = addr[1:0] occupies bits [8k+7:8k].
  - Half at addr[1]: bits [15:0] or [31:16].
- mem_MemRead and mem_MemWrite are never high in the same cycle. Both are 0 in IDLE, LD_CAP and ERR.
- mem_address is driven from latched request state in every non-IDLE state and is 0 in IDLE.
- Unused upper bits of req_wdata are ignored for sub-word stores.
- Address wrap-around does not exist; out-of-range is an error.

Optional Feature:
- LSU_SUBWORD_EN defined: byte/half loads and stores behave as above.
- LSU_SUBWORD_EN undefined: only req_size == 2 is legal. Sizes 0, 1 and 3 take the ERR path (resp_err=1). RMW_RD and RMW_WR and the lane-merge logic are not built.

Test Plan:
- Word store 0xDEADBEEF to addr 0x10, then word load from 0x10 -> mem_MemWrite pulses with mem_address=4; load resp_valid 3 cycles after accept with resp_rdata=0xDEADBEEF, resp_err=0.
- With word 0x11223344 at addr 0x20: signed byte load from 0x23 -> 0x00000011; signed half load from 0x22 -> 0x00001122; after storing byte 0x80 to 0x20, signed byte load from 0x20 -> 0xFFFFFF80 and unsigned -> 0x00000080.
- Sub-word stores: byte store 0xAB to 0x21 over 0x11223344 -> memory word becomes 0x1122AB44. Half store 0xBEEF to 0x22 -> 0xBEEFAB44. RMW sequence: one read strobe, then one write strobe.
- Errors: word load from 0x06, half store to 0x03, size 3, and addr 0x1000 with DEPTH=1024 -> resp_err=1, resp_rdata=0, 2-cycle latency, no mem strobe.
- Back-to-back: req_valid held high with a stream of 4 word loads -> each new request accepted in the same cycle as the previous resp_valid; req_ready low in all intermediate states.
- Reset asserted during ST_WR and during RMW_WR -> no mem_MemWrite, target word unchanged, no resp_valid; unit returns to IDLE with req_ready=1 after rst_n deasserts.
